// File: rtl/lfsr_rng.sv
// Memory-mapped Fibonacci LFSR random source for the 6502 I/O space.
// Supports a seedable state, free-run or single-step advance, and coherent multi-byte reads through a snapshot.
// Note: the read-data port is named dout because "do" is a reserved word in SystemVerilog.
module lfsr_rng #(
  parameter int          WIDTH        = 16,
  parameter logic [31:0] TAPS         = 32'h0000_B400,
  parameter logic [31:0] DEFAULT_SEED = 32'h0000_BABE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] di,
  output logic [7:0] dout
);

  localparam int             NBYTES    = WIDTH / 8;
  localparam logic [WIDTH-1:0] TAP_MASK  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_INIT = DEFAULT_SEED[WIDTH-1:0];

  logic [WIDTH-1:0] state_reg, state_next;
  logic [WIDTH-1:0] origin_reg, origin_next;
  logic [WIDTH-1:0] seed_reg, seed_next;
  logic             run_reg, run_next;
  logic             zrej_reg, zrej_next;
  logic             wrap_reg, wrap_next;

  logic             ctrl_wr, status_rd, snap_rd;
  logic             reseed, advance, fb;
  logic [WIDTH-1:0] shifted;
  logic [7:0]       data_byte [NBYTES];

  assign ctrl_wr   = cs &  we & (addr == 3'd4);
  assign status_rd = cs & ~we & (addr == 3'd5);
  assign snap_rd   = cs & ~we & (addr == 3'd0);
  assign reseed    = ctrl_wr & di[2];
  assign advance   = ~reseed & (run_reg | (ctrl_wr & di[1]));
  assign fb        = ^(state_reg & TAP_MASK);
  assign shifted   = {state_reg[WIDTH-2:0], fb};

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      assign seed_next[gi*8 +: 8] = (cs && we && addr == 3'(gi)) ? di : seed_reg[gi*8 +: 8];

      // Byte 0 always reads live; higher bytes read the copy taken at the last byte-0 read.
      if (gi == 0) begin : g_live
        assign data_byte[gi] = state_reg[7:0];
      end else begin : g_snap
        logic [7:0] snap_reg;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            snap_reg <= 8'h00;
          end else if (snap_rd) begin
            snap_reg <= state_reg[gi*8 +: 8];
          end
        end
        assign data_byte[gi] = snap_reg;
      end
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    origin_next = origin_reg;
    run_next    = ctrl_wr ? di[0] : run_reg;
    zrej_next   = zrej_reg & ~status_rd;
    wrap_next   = wrap_reg & ~status_rd;
    // The seed source is the staged value from before this edge.
    if (reseed) begin
      if (seed_reg == '0) begin
        state_next  = SEED_INIT;
        origin_next = SEED_INIT;
        zrej_next   = 1'b1;
      end else begin
        state_next  = seed_reg;
        origin_next = seed_reg;
      end
    end else if (advance) begin
      state_next = shifted;
      if (shifted == origin_reg) begin
        wrap_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= SEED_INIT;
      origin_reg <= SEED_INIT;
      seed_reg   <= '0;
      run_reg    <= 1'b0;
      zrej_reg   <= 1'b0;
      wrap_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      origin_reg <= origin_next;
      seed_reg   <= seed_next;
      run_reg    <= run_next;
      zrej_reg   <= zrej_next;
      wrap_reg   <= wrap_next;
    end
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      3'd4: dout = {7'd0, run_reg};
      3'd5: dout = {5'd0, wrap_reg, zrej_reg, run_reg};
      default: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (addr == 3'(i)) begin
            dout = data_byte[i];
          end
        end
      end
    endcase
  end

endmodule
